// File: rtl/lif_step_neuron.sv
// Leaky integrate-and-fire neuron driven by the A/B/C timestep phase sequencer.
// Ports: clk/rst, phase, frame_clr, syn_valid/syn_weight in;
//        v_mem, spike_valid/spike_out, spike_cnt, step_idx, done, err out.
module lif_step_neuron #(
   parameter int W_WIDTH    = 8,
   parameter int V_WIDTH    = 16,
   parameter int THRESH     = 64,
   parameter int LEAK_SHIFT = 3,
   parameter int T_STEPS    = 10,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [1:0]                  phase,
   input  logic                        frame_clr,
   input  logic                        syn_valid,
   input  logic signed [W_WIDTH-1:0]   syn_weight,
   output logic signed [V_WIDTH-1:0]   v_mem,
   output logic                        spike_valid,
   output logic                        spike_out,
   output logic [CNT_WIDTH-1:0]        spike_cnt,
   output logic [CNT_WIDTH-1:0]        step_idx,
   output logic                        done,
   output logic                        err
);

   typedef enum logic {S_RUN, S_DONE} state_t;

   localparam logic [1:0] PH_A = 2'b00;
   localparam logic [1:0] PH_B = 2'b01;
   localparam logic [1:0] PH_C = 2'b10;

   localparam logic signed [V_WIDTH-1:0] TH = V_WIDTH'(THRESH);
   localparam logic [CNT_WIDTH-1:0] T_LAST = CNT_WIDTH'(T_STEPS);
   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t state_q, state_d;
   logic [1:0] phase_q;
   logic entry;

   logic signed [V_WIDTH-1:0] v_d;
   logic signed [V_WIDTH-1:0] leak_v;
   logic signed [V_WIDTH-1:0] sat_v;
   logic signed [V_WIDTH:0]   sum;
   logic [CNT_WIDTH-1:0]      cnt_d;
   logic [CNT_WIDTH-1:0]      idx_d;
   logic                      sv_d;
   logic                      so_d;
   logic                      err_d;

   assign entry = (phase != phase_q);
   assign done  = (state_q == S_DONE);

   // Arithmetic shift rounds toward -inf, so negative values decay to 0.
   assign leak_v = v_mem - (v_mem >>> LEAK_SHIFT);

   // One guard bit: overflow shows as the top two bits disagreeing.
   always_comb begin
      sum = (V_WIDTH+1)'(v_mem) + (V_WIDTH+1)'(syn_weight);
      if (sum[V_WIDTH] != sum[V_WIDTH-1])
         sat_v = {sum[V_WIDTH], {(V_WIDTH-1){~sum[V_WIDTH]}}};
      else
         sat_v = sum[V_WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      v_d     = v_mem;
      cnt_d   = spike_cnt;
      idx_d   = step_idx;
      sv_d    = 1'b0;
      so_d    = spike_out;
      err_d   = err;
      if (frame_clr) begin
         v_d     = '0;
         cnt_d   = '0;
         idx_d   = '0;
         state_d = S_RUN;
      end else if (phase == 2'b11) begin
         err_d = 1'b1;
      end else if (state_q == S_RUN) begin
         unique case (1'b1)
            (phase == PH_A): begin
               if (entry)
                  v_d = leak_v;
            end
            (phase == PH_B): begin
               if (syn_valid)
                  v_d = sat_v;
            end
            (phase == PH_C): begin
               if (entry) begin
                  sv_d  = 1'b1;
                  idx_d = step_idx + ONE;
                  if (v_mem >= TH) begin
                     so_d  = 1'b1;
                     v_d   = '0;
                     cnt_d = spike_cnt + ONE;
                  end else begin
                     so_d = 1'b0;
                  end
                  if (idx_d == T_LAST)
                     state_d = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         phase_q     <= 2'b00;
         v_mem       <= '0;
         spike_cnt   <= '0;
         step_idx    <= '0;
         spike_valid <= 1'b0;
         spike_out   <= 1'b0;
         err         <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase;
         v_mem       <= v_d;
         spike_cnt   <= cnt_d;
         step_idx    <= idx_d;
         spike_valid <= sv_d;
         spike_out   <= so_d;
         err         <= err_d;
      end
   end

endmodule

// File: doc/lif_step_neuron.md
Name: lif_step_neuron

Overview:
- Integrate-and-fire neuron stage placed directly downstream of the A/B/C timestep phase sequencer.
- Consumes the sequencer's 2-bit phase code:
  - A (00): leak
  - B (01): integrate
  - C (10): fire evaluation
- Accumulates synaptic weights into a signed membrane potential, fires and resets on threshold, and counts spikes over a frame of T_STEPS timesteps.
- Feeds the per-layer spike buffer and goodness accumulator.

Parameters:
- W_WIDTH, 8: signed synaptic weight width.
- V_WIDTH, 16: signed membrane potential width (V_WIDTH > W_WIDTH).
- THRESH, 64: firing threshold, signed V_WIDTH value, compared with v >= THRESH.
- LEAK_SHIFT, 3: leak amount per step is v >>> LEAK_SHIFT.
- T_STEPS, 10: number of fire evaluations per frame.
- CNT_WIDTH, 4: width of step_idx and spike_cnt (must hold T_STEPS).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- phase, input, 2: phase code from the sequencer (00=A, 01=B, 10=C, 11=illegal).
- frame_clr, input, 1: one-cycle pulse that starts a new frame.
- syn_valid, input, 1: a synaptic weight is present this cycle.
- syn_weight, input, W_WIDTH: signed weight.
- v_mem, output, V_WIDTH: signed membrane potential (registered).
- spike_valid, output, 1: one-cycle pulse marking a completed fire evaluation.
- spike_out, output, 1: fire result, qualified by spike_valid.
- spike_cnt, output, CNT_WIDTH: spikes fired in the current frame.
- step_idx, output, CNT_WIDTH: fire evaluations completed in the current frame.
- done, output, 1: frame complete, sticky.
- err, output, 1: illegal phase seen, sticky.

Behaviour:
- Reset (rst=1 at a clk edge):
  - v_mem, spike_valid, spike_out, spike_cnt, step_idx, done and err all go to 0.
  - Internal phase_q goes to 00. The FSM goes to RUN.
- phase_q registers phase every cycle. Phase entry is defined as phase != phase_q.
- FSM states:
  - RUN: processes phases.
  - DONE: entered after the evaluation that makes step_idx reach T_STEPS; done=1.
  - Leave DONE only via frame_clr (to RUN) or rst.
- Priority per edge: rst > frame_clr > phase action.
- frame_clr (not in reset):
  - v_mem, spike_cnt, step_idx, done and spike_valid go to 0; err holds.
  - FSM goes to RUN.
  - Any concurrent syn_valid is dropped.
- Phase A, on its entry cycle only, in RUN: v_mem <= v_mem - (v_mem >>> LEAK_SHIFT), arithmetic shift.
  - Negative values leak toward 0; -1 leaks to 0.
- Phase B, every cycle with syn_valid=1, in RUN: v_mem <= sat(v_mem + sext(syn_weight)).
  - Saturates to the V_WIDTH signed max/min; never wraps.
  - syn_valid outside B is ignored.
- Phase C, on its entry cycle only, in RUN: compare the registered v_mem with THRESH.
  - If v_mem >= THRESH: spike_out <= 1, v_mem <= 0, spike_cnt <= spike_cnt + 1.
  - Otherwise: spike_out <= 0 and v_mem holds.
  - In both cases: step_idx <= step_idx + 1 and spike_valid <= 1 for exactly one cycle.
  - Latency: spike_valid is high in the cycle after the first C cycle.
- Staying in C (the sequencer holds C once its counter passes 10):
  - No further evaluations and no spike_valid pulses.
- When step_idx reaches T_STEPS:
  - The FSM enters DONE on the same edge; done=1 from the next cycle.
  - In DONE, A/B/C actions are suppressed and v_mem, spike_cnt and step_idx hold.
- Phase 11:
  - err <= 1.
  - No v_mem change.
  - phase_q still updates.
- spike_out holds its last value between spike_valid pulses.
- Counters never wrap: spike_cnt <= step_idx <= T_STEPS.

Test Plan:
- Basic fire: rst, then frame_clr, then A→B(syn_valid, w=70)→C.
  - Expect, one cycle after C entry: spike_valid=1, spike_out=1, v_mem=0, spike_cnt=1, step_idx=1.
- Subthreshold plus leak: B(w=40)→C→A→B(w=30)→C.
  - First C: spike_out=0, v_mem=40.
  - After A: v_mem=35.
  - Second C: spike_out=1, v_mem=0.
- Saturation, with V_WIDTH=8, THRESH=100: two B cycles with w=-128.
  - Expect v_mem=-128 (no wrap to 0).
  - Next A: v_mem=-112.
- Frame end: 10 A/B/C steps, each with w=70, then phase held at C for 20 cycles with syn_valid=1 and w=70.
  - Expect step_idx=10, spike_cnt=10 and done=1.
  - No further spike_valid pulses; v_mem stays 0.
  - frame_clr then sets done=0, step_idx=0 and spike_cnt=0.
- Collision: frame_clr in the same cycle as B with syn_valid=1, w=50.
  - Expect v_mem=0 next cycle.
- Illegal phase: phase=11 for 1 cycle with v_mem=20.
  - Expect err=1 (sticky through frame_clr), v_mem=20.
  - rst clears err.
